hex_mul_seq_ctrl: RTL and testbench

- Sequences one 8x8 unsigned multiply over the shared registered 4x4 nibble multiplier as four partial-product passes.
- Drives the multiplier's 3-bit state code and its nibble operands, accumulates the shifted partial products, and returns a 16-bit product.
- Uses a start/busy/done handshake.
- Sits between the hex-entry front end and the display/result register.

---
 rtl/hex_mul_seq_ctrl_if.sv | 21 ++
 rtl/hex_mul_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hex_mul_seq_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_mul_seq_ctrl_if.sv
// Front-end side of the multiply sequencer: start/busy/done handshake, operands and result.
// The abort wire exists only when HEX_MUL_SEQ_CTRL_ABORT_EN is defined.
interface hex_mul_seq_ctrl_if #(
    parameter int ACC_W = 16
);
    logic             start;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;
`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
    logic             abort;

    modport master (output start, op_a, op_b, abort, input busy, done, result);
    modport slave  (input start, op_a, op_b, abort, output busy, done, result);
`else
    modport master (output start, op_a, op_b, input busy, done, result);
    modport slave  (input start, op_a, op_b, output busy, done, result);
`endif
endinterface

// File: rtl/hex_mul_seq_ctrl.sv
// Sequences one 8x8 unsigned multiply as four nibble passes over a shared registered 4x4 multiplier.
// Defining HEX_MUL_SEQ_CTRL_ABORT_EN adds an abort input that cancels a running sequence.
//
// state  | meaning
// IDLE   | waiting for start, multiplier parked at code 000
// C1..C4 | one partial-product pass each, nibble pair driven to the multiplier
// DRAIN  | MUL_LAT cycles waiting for the last product; exit edge writes result
module hex_mul_seq_ctrl #(
    parameter int MUL_LAT = 1,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    hex_mul_seq_ctrl_if.slave host,
    output logic [2:0]        mul_state,
    output logic [3:0]        mul_in_1,
    output logic [3:0]        mul_in_2,
    input  logic [15:0]       mul_out
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_C1,
        S_C2,
        S_C3,
        S_C4,
        S_DRAIN
    } state_t;

    localparam logic [1:0] DRAIN_LOAD = 2'(MUL_LAT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         a_q;
    logic [7:0]         b_q;
    logic [ACC_W-1:0]   acc_q;
    logic [MUL_LAT-1:0] tap_q;
    logic [1:0]         drain_cnt_q;
    logic               accept;
    logic               finish;
    logic               abort_req;
    logic               in_compute;
    logic [2:0]         mul_state_d;
    logic [3:0]         mul_in_1_d;
    logic [3:0]         mul_in_2_d;

`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
    assign abort_req = host.abort && (state_q != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign in_compute = (state_q == S_C1) || (state_q == S_C2) ||
                        (state_q == S_C3) || (state_q == S_C4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        finish      = 1'b0;
        mul_state_d = 3'b000;
        mul_in_1_d  = 4'h0;
        mul_in_2_d  = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    state_d = S_C1;
                    accept  = 1'b1;
                end
            end
            S_C1:    state_d = S_C2;
            S_C2:    state_d = S_C3;
            S_C3:    state_d = S_C4;
            S_C4:    state_d = S_DRAIN;
            S_DRAIN: begin
                if (drain_cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides everything, including the result edge
        if (abort_req) begin
            state_d = S_IDLE;
            finish  = 1'b0;
        end

        // C1 is only reached from the accept edge, so it takes the live operands
        case (state_d)
            S_C1: begin
                mul_state_d = 3'b001;
                mul_in_1_d  = host.op_a[3:0];
                mul_in_2_d  = host.op_b[3:0];
            end
            S_C2: begin
                mul_state_d = 3'b010;
                mul_in_1_d  = a_q[7:4];
                mul_in_2_d  = b_q[3:0];
            end
            S_C3: begin
                mul_state_d = 3'b011;
                mul_in_1_d  = a_q[3:0];
                mul_in_2_d  = b_q[7:4];
            end
            S_C4: begin
                mul_state_d = 3'b100;
                mul_in_1_d  = a_q[7:4];
                mul_in_2_d  = b_q[7:4];
            end
            default: begin
                mul_state_d = 3'b000;
                mul_in_1_d  = 4'h0;
                mul_in_2_d  = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= '0;
            tap_q       <= '0;
            drain_cnt_q <= 2'd0;
            mul_state   <= 3'b000;
            mul_in_1    <= 4'h0;
            mul_in_2    <= 4'h0;
            host.busy   <= 1'b0;
            host.done   <= 1'b0;
            host.result <= '0;
        end else begin
            if (accept) begin
                a_q <= host.op_a;
                b_q <= host.op_b;
            end

            mul_state <= mul_state_d;
            mul_in_1  <= mul_in_1_d;
            mul_in_2  <= mul_in_2_d;

            if (state_q == S_C4) begin
                drain_cnt_q <= DRAIN_LOAD;
            end else if ((state_q == S_DRAIN) && (drain_cnt_q != 2'd0)) begin
                drain_cnt_q <= drain_cnt_q - 2'd1;
            end

            // tap marks the cycles where mul_out carries a pass result
            if (abort_req) begin
                tap_q <= '0;
            end else begin
                tap_q[0] <= in_compute;
                for (int i = 1; i < MUL_LAT; i++) begin
                    tap_q[i] <= tap_q[i-1];
                end
            end

            if (accept || abort_req) begin
                acc_q <= '0;
            end else if (tap_q[MUL_LAT-1]) begin
                acc_q <= acc_q + ACC_W'(mul_out);
            end

            if (accept) begin
                host.busy <= 1'b1;
            end else if (finish || abort_req) begin
                host.busy <= 1'b0;
            end

            host.done <= finish;

            if (finish) begin
                host.result <= acc_q + ACC_W'(mul_out);
            end
        end
    end
endmodule

// File: tb/tb_hex_mul_seq_ctrl.sv
// Bench for hex_mul_seq_ctrl: two instances (MUL_LAT=1 and MUL_LAT=2) share stimulus,
// each driving its own registered nibble-multiplier model; results checked against a*b.
module tb_hex_mul_seq_ctrl;
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] op_a  = 8'h00;
    logic [7:0] op_b  = 8'h00;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hex_mul_seq_ctrl_if #(.ACC_W(16)) bus1 ();
    hex_mul_seq_ctrl_if #(.ACC_W(16)) bus2 ();

    assign bus1.start = start;
    assign bus1.op_a  = op_a;
    assign bus1.op_b  = op_b;
    assign bus2.start = start;
    assign bus2.op_a  = op_a;
    assign bus2.op_b  = op_b;

`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
    logic abort    = 1'b0;
    int   abort_at = -1;
    assign bus1.abort = abort;
    assign bus2.abort = abort;
`endif

    logic [2:0]  ms1, ms2;
    logic [3:0]  a1, b1, a2, b2;
    logic [15:0] mo1   = 16'h0;
    logic [15:0] m2_s0 = 16'h0;
    logic [15:0] mo2   = 16'h0;

    hex_mul_seq_ctrl #(.MUL_LAT(1), .ACC_W(16)) dut1 (
        .clk(clk), .rst(rst), .host(bus1),
        .mul_state(ms1), .mul_in_1(a1), .mul_in_2(b1), .mul_out(mo1)
    );

    hex_mul_seq_ctrl #(.MUL_LAT(2), .ACC_W(16)) dut2 (
        .clk(clk), .rst(rst), .host(bus2),
        .mul_state(ms2), .mul_in_1(a2), .mul_in_2(b2), .mul_out(mo2)
    );

    // registered 4x4 multiplier that applies the per-pass shift itself
    function automatic logic [15:0] pp(input logic [2:0] st, input logic [3:0] x, input logic [3:0] y);
        logic [15:0] p;
        p = {12'd0, x} * {12'd0, y};
        case (st)
            3'd1:       return p;
            3'd2, 3'd3: return p << 4;
            3'd4:       return p << 8;
            default:    return 16'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        mo1   <= pp(ms1, a1, b1);
        m2_s0 <= pp(ms2, a2, b2);
        mo2   <= m2_s0;
    end

    logic [2:0]  st_obs  [2][16];
    logic [3:0]  n1_obs  [2][16];
    logic [3:0]  n2_obs  [2][16];
    logic        bsy_obs [2][16];
    int          done_cnt[2];
    int          done_cyc[2];
    int          busy_cnt[2];
    logic [15:0] res_obs [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one operation; cycle c is the interval after edge E(c-1), E0 being the accept edge
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0;
            done_cyc[k] = -1;
            busy_cnt[k] = 0;
            res_obs[k]  = 16'h0;
        end
        start = 1'b1;
        op_a  = a;
        op_b  = b;
`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
        abort = (abort_at == 0);
`endif
        tick();
        for (int c = 1; c < 12; c++) begin
            st_obs[0][c] = ms1;  n1_obs[0][c] = a1; n2_obs[0][c] = b1; bsy_obs[0][c] = bus1.busy;
            st_obs[1][c] = ms2;  n1_obs[1][c] = a2; n2_obs[1][c] = b2; bsy_obs[1][c] = bus2.busy;
            if (bus1.done) begin done_cnt[0]++; done_cyc[0] = c; res_obs[0] = bus1.result; end
            if (bus2.done) begin done_cnt[1]++; done_cyc[1] = c; res_obs[1] = bus2.result; end
            if (bus1.busy) busy_cnt[0]++;
            if (bus2.busy) busy_cnt[1]++;
            start = poke && (c <= 5) && ($urandom_range(0, 1) == 1);
            op_a  = 8'($urandom);
            op_b  = 8'($urandom);
`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
            abort = (c == abort_at);
`endif
            tick();
        end
        start = 1'b0;
`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vectors++;
        if ({ms1, a1, b1, bus1.busy, bus1.done, bus1.result} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_dut1: got state=%0d nib=%h/%h busy=%b done=%b result=%h, want all 0",
                     ms1, a1, b1, bus1.busy, bus1.done, bus1.result);
        end
        vectors++;
        if ({ms2, a2, b2, bus2.busy, bus2.done, bus2.result} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_dut2: got state=%0d nib=%h/%h busy=%b done=%b result=%h, want all 0",
                     ms2, a2, b2, bus2.busy, bus2.done, bus2.result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] a, b;
        logic [3:0] e1, e2;
        a = 8'hAB;
        b = 8'hCD;
        run_op(a, b, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                e1 = p[0] ? a[7:4] : a[3:0];
                e2 = p[1] ? b[7:4] : b[3:0];
                vectors++;
                if (st_obs[k][p+1] !== 3'(p + 1) || n1_obs[k][p+1] !== e1 || n2_obs[k][p+1] !== e2) begin
                    miscompares++;
                    $display("FAIL trace lat%0d pass%0d: got code=%0d nib=%h/%h, want code=%0d nib=%h/%h",
                             k + 1, p + 1, st_obs[k][p+1], n1_obs[k][p+1], n2_obs[k][p+1], p + 1, e1, e2);
                end
            end
            vectors++;
            if (st_obs[k][5] !== 3'd0) begin
                miscompares++;
                $display("FAIL drain_code lat%0d: got %0d, want 0", k + 1, st_obs[k][5]);
            end
            vectors++;
            if (done_cnt[k] != 1 || done_cyc[k] != 6 + k) begin
                miscompares++;
                $display("FAIL done_timing lat%0d: got count=%0d cycle=%0d, want count=1 cycle=%0d",
                         k + 1, done_cnt[k], done_cyc[k], 6 + k);
            end
            vectors++;
            if (busy_cnt[k] != 5 + k) begin
                miscompares++;
                $display("FAIL busy_len lat%0d: got %0d, want %0d", k + 1, busy_cnt[k], 5 + k);
            end
            vectors++;
            if (res_obs[k] !== 16'h88EF) begin
                miscompares++;
                $display("FAIL result_abcd lat%0d: got %h, want 88ef", k + 1, res_obs[k]);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0] av [2];
        logic [7:0] bv [2];
        logic [15:0] exp;
        av[0] = 8'hFF; bv[0] = 8'hFF;
        av[1] = 8'h00; bv[1] = 8'h5A;
        for (int t = 0; t < 2; t++) begin
            run_op(av[t], bv[t], 1'b0);
            exp = 16'(av[t]) * 16'(bv[t]);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (done_cnt[k] != 1 || res_obs[k] !== exp) begin
                    miscompares++;
                    $display("FAIL corner %h*%h lat%0d: got done=%0d result=%h, want done=1 result=%h",
                             av[t], bv[t], k + 1, done_cnt[k], res_obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        start = 1'b1; op_a = 8'hAB; op_b = 8'hCD;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (ms1 !== 3'd3 || ms2 !== 3'd3) begin
            miscompares++;
            $display("FAIL pre_reset_code: got %0d/%0d, want 3/3", ms1, ms2);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({ms1, a1, b1, bus1.busy, bus1.done, bus1.result, ms2, a2, b2, bus2.busy, bus2.done, bus2.result} !== 58'd0) begin
            miscompares++;
            $display("FAIL async_reset: got codes=%0d/%0d busy=%b/%b result=%h/%h, want all 0",
                     ms1, ms2, bus1.busy, bus2.busy, bus1.result, bus2.result);
        end
        tick();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus1.done || bus2.done) n++;
            tick();
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL no_done_after_reset: got %0d done pulses, want 0", n);
        end
        run_op(8'h02, 8'h03, 1'b0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_cnt[k] != 1 || res_obs[k] !== 16'h0006) begin
                miscompares++;
                $display("FAIL post_reset_op lat%0d: got done=%0d result=%h, want done=1 result=0006",
                         k + 1, done_cnt[k], res_obs[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          nd   [2];
        int          d_cyc[2][2];
        logic [15:0] d_res[2][2];
        logic [15:0] exp0, exp1;
        exp0 = 16'(8'h12) * 16'(8'h34);
        exp1 = 16'(8'h0F) * 16'(8'h10);
        for (int k = 0; k < 2; k++) begin
            nd[k] = 0;
            d_cyc[k][0] = -1; d_cyc[k][1] = -1;
            d_res[k][0] = 16'h0; d_res[k][1] = 16'h0;
        end
        start = 1'b1; op_a = 8'h12; op_b = 8'h34;
        tick();
        op_a = 8'h0F; op_b = 8'h10;
        for (int c = 1; c < 20; c++) begin
            if (bus1.done) begin
                if (nd[0] < 2) begin d_cyc[0][nd[0]] = c; d_res[0][nd[0]] = bus1.result; end
                nd[0]++;
            end
            if (bus2.done) begin
                if (nd[1] < 2) begin d_cyc[1][nd[1]] = c; d_res[1][nd[1]] = bus2.result; end
                nd[1]++;
            end
            start = (c <= 7);
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (nd[k] != 2 || d_res[k][0] !== exp0 || d_res[k][1] !== exp1) begin
                miscompares++;
                $display("FAIL b2b_results lat%0d: got count=%0d results=%h,%h, want count=2 results=%h,%h",
                         k + 1, nd[k], d_res[k][0], d_res[k][1], exp0, exp1);
            end
            // a held start is taken in the IDLE cycle that follows each done
            vectors++;
            if (d_cyc[k][0] != 6 + k || d_cyc[k][1] - d_cyc[k][0] != 6 + k) begin
                miscompares++;
                $display("FAIL b2b_spacing lat%0d: got done cycles %0d,%0d, want %0d,%0d",
                         k + 1, d_cyc[k][0], d_cyc[k][1], 6 + k, 12 + 2 * k);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [3:0]  e1, e2;
        logic [15:0] exp;
        bit          ok;
        for (int t = 0; t < 16; t++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            exp = 16'(a) * 16'(b);
            run_op(a, b, 1'b1);
            for (int k = 0; k < 2; k++) begin
                ok = 1'b1;
                for (int p = 0; p < 4; p++) begin
                    e1 = p[0] ? a[7:4] : a[3:0];
                    e2 = p[1] ? b[7:4] : b[3:0];
                    if (st_obs[k][p+1] !== 3'(p + 1) || n1_obs[k][p+1] !== e1 || n2_obs[k][p+1] !== e2) ok = 1'b0;
                end
                vectors++;
                if (!ok || done_cnt[k] != 1 || done_cyc[k] != 6 + k || res_obs[k] !== exp) begin
                    miscompares++;
                    $display("FAIL random %h*%h lat%0d: got trace_ok=%b done=%0d@%0d result=%h, want trace_ok=1 done=1@%0d result=%h",
                             a, b, k + 1, ok, done_cnt[k], done_cyc[k], res_obs[k], 6 + k, exp);
                end
            end
        end
    endtask

`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
    task automatic test_abort();
        logic [7:0]  a, b;
        logic [15:0] prev;
        abort_at = -1;
        run_op(8'hAB, 8'hCD, 1'b0);
        prev = 16'h88EF;
        abort_at = 2;
        run_op(8'($urandom), 8'($urandom), 1'b0);
        vectors++;
        if (done_cnt[0] != 0 || done_cnt[1] != 0 || bsy_obs[0][3] !== 1'b0 || bsy_obs[1][3] !== 1'b0 ||
            st_obs[0][3] !== 3'd0 || st_obs[1][3] !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_c2: got done=%0d/%0d busy=%b/%b code=%0d/%0d, want done=0/0 busy=0/0 code=0/0",
                     done_cnt[0], done_cnt[1], bsy_obs[0][3], bsy_obs[1][3], st_obs[0][3], st_obs[1][3]);
        end
        vectors++;
        if (bus1.result !== prev || bus2.result !== prev) begin
            miscompares++;
            $display("FAIL abort_keeps_result: got %h/%h, want %h", bus1.result, bus2.result, prev);
        end
        abort_at = 0;
        a = 8'($urandom);
        b = 8'($urandom);
        run_op(a, b, 1'b0);
        prev = 16'(a) * 16'(b);
        vectors++;
        if (done_cnt[0] != 1 || done_cnt[1] != 1 || res_obs[0] !== prev || res_obs[1] !== prev) begin
            miscompares++;
            $display("FAIL abort_in_idle: got done=%0d/%0d result=%h/%h, want done=1/1 result=%h",
                     done_cnt[0], done_cnt[1], res_obs[0], res_obs[1], prev);
        end
        abort_at = 5;
        run_op(8'($urandom), 8'($urandom), 1'b0);
        vectors++;
        if (done_cnt[0] != 0 || done_cnt[1] != 0 || bus1.result !== prev || bus2.result !== prev ||
            bsy_obs[0][6] !== 1'b0 || bsy_obs[1][6] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_result_edge: got done=%0d/%0d result=%h/%h busy=%b/%b, want done=0/0 result=%h busy=0/0",
                     done_cnt[0], done_cnt[1], bus1.result, bus2.result, bsy_obs[0][6], bsy_obs[1][6], prev);
        end
        abort_at = -1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_corners();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
`ifdef HEX_MUL_SEQ_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
